enigma_rotor_engine: RTL and testbench

- Sequential encipher engine that sits directly upstream of the six-channel rotor ROM: drives its six addresses and consumes its six data words.
- Accepts one plaintext letter at a time and applies Enigma stepping, including the double-step.
- Walks the letter forward through three rotors, through the reflector, then backward, and emits the ciphertext letter with a valid/ready handshake.
- Holds rotor types and positions; the plugboard and ring settings are out of scope.

---
 rtl/enigma_pkg.sv | 28 ++
 rtl/enigma_stepper.sv | 20 ++
 rtl/enigma_rotor_engine.sv | 103 ++++++++++
 tb/tb_enigma_rotor_engine.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared constants, state encoding and mod-26 helpers for the rotor engine
package enigma_pkg;
  localparam int ALPHA = 26;
  localparam int NTYPES = 5;
  localparam int STRIDE = 2 * ALPHA;
  localparam logic [4:0] NOTCH [0:4] = '{5'd16, 5'd4, 5'd21, 5'd9, 5'd25};
  localparam logic [4:0] UKW_B [0:25] = '{
    5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23, 5'd13, 5'd6, 5'd14,
    5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19
  };
  typedef enum logic [3:0] {
    S_IDLE, S_STEP, S_F0, S_F1, S_F2, S_REFL, S_B2, S_B1, S_B0, S_OUT
  } state_t;
  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s >= 6'(ALPHA) ? 5'(s - 6'(ALPHA)) : s[4:0];
  endfunction
  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[5] ? 5'(d + 6'(ALPHA)) : d[4:0];
  endfunction
  // Each rotor type owns 52 rows: 26 forward entries followed by 26 inverse entries.
  function automatic logic [8:0] rom_addr(input logic [2:0] t, input logic back, input logic [4:0] idx);
    return 9'(t) * 9'(STRIDE) + (back ? 9'(ALPHA) : 9'd0) + 9'(idx);
  endfunction
endpackage

// File: rtl/enigma_stepper.sv
// enigma_stepper: rotor advance with notch-driven carry and the middle-rotor double-step
module enigma_stepper
  import enigma_pkg::*;
(
  input  logic [2:0] type0,
  input  logic [2:0] type1,
  input  logic [4:0] pos0,
  input  logic [4:0] pos1,
  input  logic [4:0] pos2,
  output logic [4:0] npos0,
  output logic [4:0] npos1,
  output logic [4:0] npos2
);
  logic at0, at1;
  assign at0 = pos0 == NOTCH[type0];
  assign at1 = pos1 == NOTCH[type1];
  assign npos0 = add26(pos0, 5'd1);
  assign npos1 = (at0 || at1) ? add26(pos1, 5'd1) : pos1;
  assign npos2 = at1 ? add26(pos2, 5'd1) : pos2;
endmodule

// File: rtl/enigma_rotor_engine.sv
// enigma_rotor_engine: one-letter-at-a-time Enigma encipher walking an external rotor ROM
module enigma_rotor_engine
  import enigma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_load,
  input  logic [2:0]  cfg_type0,
  input  logic [2:0]  cfg_type1,
  input  logic [2:0]  cfg_type2,
  input  logic [4:0]  cfg_pos0,
  input  logic [4:0]  cfg_pos1,
  input  logic [4:0]  cfg_pos2,
  output logic        cfg_err,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_letter,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_letter,
  output logic [4:0]  pos0,
  output logic [4:0]  pos1,
  output logic [4:0]  pos2,
  output logic [8:0]  rom_addr0,
  output logic [8:0]  rom_addr1,
  output logic [8:0]  rom_addr2,
  output logic [8:0]  rom_addr3,
  output logic [8:0]  rom_addr4,
  output logic [8:0]  rom_addr5,
  input  logic [15:0] rom_dout0,
  input  logic [15:0] rom_dout1,
  input  logic [15:0] rom_dout2,
  input  logic [15:0] rom_dout3,
  input  logic [15:0] rom_dout4,
  input  logic [15:0] rom_dout5
);
  state_t state, state_n;
  logic [2:0] typ0, typ1, typ2;
  logic [4:0] c, c_n, idx0, idx1, idx2, npos0, npos1, npos2;
  logic accept, cfg_ok, rom_unused;
  assign rom_unused = ^{rom_dout0[15:5], rom_dout1[15:5], rom_dout2[15:5],
                        rom_dout3[15:5], rom_dout4[15:5], rom_dout5[15:5]};
  assign in_ready = state == S_IDLE && !cfg_load;
  assign accept = in_valid && in_ready;
  assign out_valid = state == S_OUT;
  assign cfg_ok = cfg_type0 < 3'(NTYPES) && cfg_type1 < 3'(NTYPES) && cfg_type2 < 3'(NTYPES);
  assign idx0 = add26(c, pos0);
  assign idx1 = add26(c, pos1);
  assign idx2 = add26(c, pos2);
  assign rom_addr0 = rom_addr(typ0, 1'b0, idx0);
  assign rom_addr1 = rom_addr(typ1, 1'b0, idx1);
  assign rom_addr2 = rom_addr(typ2, 1'b0, idx2);
  assign rom_addr3 = rom_addr(typ0, 1'b1, idx0);
  assign rom_addr4 = rom_addr(typ1, 1'b1, idx1);
  assign rom_addr5 = rom_addr(typ2, 1'b1, idx2);
  enigma_stepper u_stepper (
    .type0(typ0), .type1(typ1),
    .pos0(pos0), .pos1(pos1), .pos2(pos2),
    .npos0(npos0), .npos1(npos1), .npos2(npos2)
  );
  always_comb begin
    state_n = state;
    c_n = c;
    case (state)
      S_IDLE: if (accept) begin
        state_n = S_STEP;
        c_n = add26(in_letter, 5'd0);
      end
      S_STEP: state_n = S_F0;
      S_F0: begin state_n = S_F1; c_n = sub26(rom_dout0[4:0], pos0); end
      S_F1: begin state_n = S_F2; c_n = sub26(rom_dout1[4:0], pos1); end
      S_F2: begin state_n = S_REFL; c_n = sub26(rom_dout2[4:0], pos2); end
      S_REFL: begin state_n = S_B2; c_n = UKW_B[c]; end
      S_B2: begin state_n = S_B1; c_n = sub26(rom_dout5[4:0], pos2); end
      S_B1: begin state_n = S_B0; c_n = sub26(rom_dout4[4:0], pos1); end
      S_B0: begin state_n = S_OUT; c_n = sub26(rom_dout3[4:0], pos0); end
      S_OUT: if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      c <= '0;
      out_letter <= '0;
      cfg_err <= 1'b0;
      {pos2, pos1, pos0} <= '0;
      {typ2, typ1, typ0} <= {3'd0, 3'd1, 3'd2};
    end else begin
      c <= c_n;
      cfg_err <= state == S_IDLE && cfg_load && !cfg_ok;
      if (state == S_IDLE && cfg_load && cfg_ok) begin
        {typ2, typ1, typ0} <= {cfg_type2, cfg_type1, cfg_type0};
        {pos2, pos1, pos0} <= {cfg_pos2, cfg_pos1, cfg_pos0};
      end
      if (state == S_STEP) {pos2, pos1, pos0} <= {npos2, npos1, npos0};
      if (state == S_B0) out_letter <= c_n;
    end
  end
endmodule

// File: tb/tb_enigma_rotor_engine.sv
// tb_enigma_rotor_engine: scoreboard bench against a behavioural Enigma model and historical ROM
module tb_enigma_rotor_engine;
  logic clk = 0, reset = 1, cfg_load = 0, in_valid = 0, out_ready = 1;
  logic [2:0] cfg_type0 = 0, cfg_type1 = 0, cfg_type2 = 0;
  logic [4:0] cfg_pos0 = 0, cfg_pos1 = 0, cfg_pos2 = 0, in_letter = 0;
  logic cfg_err, in_ready, out_valid;
  logic [4:0] out_letter, pos0, pos1, pos2;
  logic [8:0] rom_addr0, rom_addr1, rom_addr2, rom_addr3, rom_addr4, rom_addr5;
  logic [15:0] rom_dout0, rom_dout1, rom_dout2, rom_dout3, rom_dout4, rom_dout5;
  logic [4:0] rom [0:511];
  string w [5];
  string ukw;
  int mt [3], mp [3];
  int vectors = 0, errs = 0;
  int q [$];
  localparam int NOTCH_M [5] = '{16, 4, 21, 9, 25};

  always #5 clk = ~clk;

  assign rom_dout0 = {11'h5a5, rom[rom_addr0]};
  assign rom_dout1 = {11'h5a5, rom[rom_addr1]};
  assign rom_dout2 = {11'h5a5, rom[rom_addr2]};
  assign rom_dout3 = {11'h5a5, rom[rom_addr3]};
  assign rom_dout4 = {11'h5a5, rom[rom_addr4]};
  assign rom_dout5 = {11'h5a5, rom[rom_addr5]};

  enigma_rotor_engine dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load),
    .cfg_type0(cfg_type0), .cfg_type1(cfg_type1), .cfg_type2(cfg_type2),
    .cfg_pos0(cfg_pos0), .cfg_pos1(cfg_pos1), .cfg_pos2(cfg_pos2), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_letter(in_letter),
    .out_valid(out_valid), .out_ready(out_ready), .out_letter(out_letter),
    .pos0(pos0), .pos1(pos1), .pos2(pos2),
    .rom_addr0(rom_addr0), .rom_addr1(rom_addr1), .rom_addr2(rom_addr2),
    .rom_addr3(rom_addr3), .rom_addr4(rom_addr4), .rom_addr5(rom_addr5),
    .rom_dout0(rom_dout0), .rom_dout1(rom_dout1), .rom_dout2(rom_dout2),
    .rom_dout3(rom_dout3), .rom_dout4(rom_dout4), .rom_dout5(rom_dout5)
  );

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pk(input int p2, input int p1, input int p0);
    return p2 * 1024 + p1 * 32 + p0;
  endfunction

  function automatic int pospk();
    return int'({pos2, pos1, pos0});
  endfunction

  function automatic int fwd(input int t, input int p, input int c);
    return (int'(w[t][(c + p) % 26]) - 65 - p + 26) % 26;
  endfunction

  function automatic int bwd(input int t, input int p, input int c);
    int x = (c + p) % 26;
    for (int j = 0; j < 26; j++)
      if (int'(w[t][j]) - 65 == x) return (j - p + 26) % 26;
    return 0;
  endfunction

  function automatic int model_enc(input int l);
    int c = l;
    for (int s = 0; s < 3; s++) c = fwd(mt[s], mp[s], c);
    c = int'(ukw[c]) - 65;
    for (int s = 2; s >= 0; s--) c = bwd(mt[s], mp[s], c);
    return c;
  endfunction

  function automatic void model_step();
    bit at0 = mp[0] == NOTCH_M[mt[0]];
    bit at1 = mp[1] == NOTCH_M[mt[1]];
    mp[0] = (mp[0] + 1) % 26;
    if (at0 || at1) mp[1] = (mp[1] + 1) % 26;
    if (at1) mp[2] = (mp[2] + 1) % 26;
  endfunction

  always @(negedge clk)
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("stray_out", int'(out_valid), 0);
      else chk("sb_letter", int'(out_letter), q.pop_front());
    end

  task automatic cfg(input int t0, input int t1, input int t2, input int p0, input int p1, input int p2);
    bit ok = t0 <= 4 && t1 <= 4 && t2 <= 4;
    @(negedge clk);
    cfg_load = 1;
    cfg_type0 = 3'(t0); cfg_type1 = 3'(t1); cfg_type2 = 3'(t2);
    cfg_pos0 = 5'(p0); cfg_pos1 = 5'(p1); cfg_pos2 = 5'(p2);
    @(posedge clk); #1 cfg_load = 0;
    chk("cfg_err", int'(cfg_err), int'(!ok));
    if (ok) begin
      mt = '{t0, t1, t2};
      mp = '{p0, p1, p2};
    end
    @(posedge clk); #1;
    chk("cfg_err_pulse", int'(cfg_err), 0);
    chk("cfg_pos", pospk(), pk(mp[2], mp[1], mp[0]));
  endtask

  task automatic enc(input logic [4:0] l, output logic [4:0] got);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 30) begin @(negedge clk); n++; end
    chk("in_ready", int'(in_ready), 1);
    model_step();
    q.push_back(model_enc(int'(l) % 26));
    in_valid = 1; in_letter = l;
    @(posedge clk); #1 in_valid = 0;
    n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    chk("latency", n, 8);
    chk("pos", pospk(), pk(mp[2], mp[1], mp[0]));
    got = out_letter;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [4:0] g, hold;
    int n, seen;
    int hist [5] = '{1, 3, 25, 6, 14};
    int ds [3];
    int plain [5] = '{7, 4, 11, 11, 14};
    logic [4:0] ct [5];
    w[0] = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    w[1] = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    w[2] = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    w[3] = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
    w[4] = "VZBRGITYUPSDNHLKXWMFCAEOJQ";
    ukw = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    for (int i = 0; i < 512; i++) rom[i] = 5'd0;
    for (int t = 0; t < 5; t++)
      for (int i = 0; i < 26; i++) begin
        rom[t * 52 + i] = 5'(int'(w[t][i]) - 65);
        rom[t * 52 + 26 + int'(w[t][i]) - 65] = 5'(i);
      end
    mt = '{2, 1, 0};
    mp = '{0, 0, 0};
    ds = '{pk(0, 3, 21), pk(0, 4, 22), pk(1, 5, 23)};
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_out_letter", int'(out_letter), 0);
    chk("rst_pos", pospk(), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    // Historical AAAAA -> BDZGO with default I-II-III at AAA.
    for (int i = 0; i < 5; i++) begin
      enc(5'd0, g);
      chk("hist_letter", int'(g), hist[i]);
    end
    chk("hist_pos", pospk(), pk(0, 0, 5));
    cfg(2, 1, 0, 20, 3, 0);
    for (int i = 0; i < 3; i++) begin
      enc(5'(i), g);
      chk("dstep_pos", pospk(), ds[i]);
    end
    cfg(2, 1, 0, 25, 7, 3);
    enc(5'd4, g);
    chk("wrap_pos", pospk(), pk(3, 7, 0));
    // Backpressure: output held while out_ready is low.
    @(negedge clk);
    out_ready = 0; in_valid = 1; in_letter = 5'd9;
    model_step();
    q.push_back(model_enc(9));
    @(posedge clk); #1 in_valid = 0;
    n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    chk("bp_rise", int'(out_valid), 1);
    hold = out_letter;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_letter", int'(out_letter), int'(hold));
      chk("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1;
    chk("bp_drop", int'(out_valid), 0);
    chk("bp_ready_after", int'(in_ready), 1);
    chk("bp_sb_empty", q.size(), 0);
    // Rejected configuration leaves rotors untouched.
    cfg(2, 6, 0, 1, 2, 3);
    enc(5'd7, g);
    @(negedge clk);
    cfg_load = 1; in_valid = 1; in_letter = 5'd3;
    cfg_type0 = 3'd0; cfg_type1 = 3'd1; cfg_type2 = 3'd2;
    cfg_pos0 = 5'd5; cfg_pos1 = 5'd6; cfg_pos2 = 5'd7;
    #1 chk("cfg_in_ready", int'(in_ready), 0);
    @(posedge clk); #1 cfg_load = 0; in_valid = 0;
    mt = '{0, 1, 2};
    mp = '{5, 6, 7};
    seen = 0;
    repeat (12) begin @(negedge clk); seen |= int'(out_valid); end
    chk("cfg_no_accept", seen, 0);
    chk("cfg_prio_pos", pospk(), pk(7, 6, 5));
    // Reset while the letter is in F1.
    @(negedge clk);
    in_valid = 1; in_letter = 5'd2;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    mt = '{2, 1, 0};
    mp = '{0, 0, 0};
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_ready", int'(in_ready), 1);
    chk("midrst_pos", pospk(), 0);
    seen = 0;
    repeat (12) begin @(negedge clk); seen |= int'(out_valid); end
    chk("midrst_no_out", seen, 0);
    cfg(0, 3, 4, 3, 7, 11);
    for (int i = 0; i < 5; i++) enc(5'(plain[i]), ct[i]);
    cfg(0, 3, 4, 3, 7, 11);
    for (int i = 0; i < 5; i++) begin
      enc(ct[i], g);
      chk("recip", int'(g), plain[i]);
    end
    repeat (3) begin
      cfg(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
          int'($urandom_range(0, 25)), int'($urandom_range(0, 25)), int'($urandom_range(0, 25)));
      repeat (4) enc(5'($urandom_range(0, 31)), g);
    end
    enc(5'd31, g);
    chk("final_sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
